// File: rtl/if_insn_queue.sv
// if_insn_queue: the ID-side end of the IF/ID pipeline register.
// A small FIFO of {pc, pc_plus4, insn} triples. It holds IF back with if_stall
// when full, hands the head entry to ID over valid/ready, and flush empties it.
`ifndef ISA_NOP
`define ISA_NOP 32'h00000013
`endif

module if_insn_queue #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      if_pc,
   input  logic [31:0]      if_pc_plus4,
   input  logic [31:0]      if_insn,
   input  logic             if_en,
   output logic             if_stall,
   input  logic             flush,
   output logic [31:0]      id_pc,
   output logic [31:0]      id_pc_plus4,
   output logic [31:0]      id_insn,
   output logic             id_valid,
   input  logic             id_ready,
   output logic [PTR_W:0]   q_count
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             push, pop;

   logic [31:0] pc_mem       [DEPTH];
   logic [31:0] pc_plus4_mem [DEPTH];
   logic [31:0] insn_mem     [DEPTH];

   // Occupancy alone separates full from empty; the pointers simply wrap.
   assign if_stall = (count_q == FULL_CNT);
   assign id_valid = (count_q != '0);
   assign q_count  = count_q;

   // Flush wins over every request; a full queue never accepts a push.
   assign push = if_en & ~if_stall & ~flush;
   assign pop  = id_valid & id_ready & ~flush;

   // Head entry is shown directly; an empty queue presents a NOP bubble.
   always_comb begin
      id_pc       = 32'h0;
      id_pc_plus4 = 32'h0;
      id_insn     = `ISA_NOP;
      if (id_valid) begin
         id_pc       = pc_mem[rd_ptr_q];
         id_pc_plus4 = pc_plus4_mem[rd_ptr_q];
         id_insn     = insn_mem[rd_ptr_q];
      end
   end

   // Next-state for pointers and occupancy.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Control state register; reset behaves like a flush.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_q]       <= if_pc;
         pc_plus4_mem[wr_ptr_q] <= if_pc_plus4;
         insn_mem[wr_ptr_q]     <= if_insn;
      end
   end

endmodule
